// File: rtl/mul_sched_pkg.sv
// Shared types and the round-robin search for the multiplier scheduler.
// Widths are sized for the largest supported configuration (8 requesters).
package mul_sched_pkg;

  localparam int MAX_REQ      = 8;
  localparam int MAX_ID_W     = 3;
  localparam int MAX_DATA_LEN = 64;

  typedef logic [MAX_ID_W-1:0] t_req_id;

  typedef struct packed {
    t_req_id                 id;
    logic [MAX_DATA_LEN-1:0] result;
  } t_rsp_entry;

  // One-hot grant of the first valid requester after ptr, searching cyclically
  // over num_req requesters; all-zero when nobody is valid.
  function automatic logic [MAX_REQ-1:0] rr_next_grant(
    input logic [MAX_REQ-1:0] valid,
    input t_req_id            ptr,
    input int                 num_req
  );
    logic [MAX_REQ-1:0] gnt;
    int                 cand;
    gnt = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= num_req && gnt == '0) begin
        cand = (int'(ptr) + k) % num_req;
        if (valid[cand]) gnt[cand] = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/mul_rr_scheduler_fifo.sv
// Show-ahead synchronous FIFO with occupancy count; head is visible while non-empty.
// Pops are ignored when empty, pushes when full unless a pop frees the slot.
module sync_fifo #(
  parameter int  DEPTH = 8,
  parameter int  WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mul_rr_scheduler.sv
// Round-robin scheduler sharing one fixed-latency pipelined multiplier among
// NUM_REQ requesters; credit accounting keeps the response FIFO from overflowing.
module mul_rr_scheduler
  import mul_sched_pkg::*;
#(
  parameter int  NUM_REQ     = 4,
  parameter int  DATA_LEN    = 32,
  parameter int  MUL_LATENCY = 3,
  parameter int  FIFO_DEPTH  = 8,
  localparam int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*DATA_LEN-1:0] req_a,
  input  logic [NUM_REQ*DATA_LEN-1:0] req_b,
  output logic [DATA_LEN-1:0]         mul_a,
  output logic [DATA_LEN-1:0]         mul_b,
  input  logic [DATA_LEN-1:0]         mul_result,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [ID_W-1:0]             rsp_id,
  output logic [DATA_LEN-1:0]         rsp_result,
  output logic                        busy,
  output logic [31:0]                 issue_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int ENT_W = ID_W + DATA_LEN;

  logic [ID_W-1:0]     ptr_q;
  logic [MUL_LATENCY:0] tag_v_q;
  logic [ID_W-1:0]     tag_id_q [MUL_LATENCY+1];
  logic [DATA_LEN-1:0] mul_a_q, mul_b_q, mul_a_d, mul_b_d;
  logic [31:0]         issue_count_q;

  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full, fifo_empty, fifo_push, fifo_pop, cap_valid;
  logic [ENT_W-1:0]    fifo_rdata;
  logic [31:0]         outstanding;
  logic                can_issue, transfer;
  logic [MAX_REQ-1:0]  valid_ext, gnt_full;
  logic [ID_W-1:0]     gnt_idx;

  // Every accepted request holds one credit from issue until its result pops.
  always_comb begin
    outstanding = 32'(fifo_count);
    for (int s = 0; s <= MUL_LATENCY; s++) begin
      outstanding = outstanding + 32'(tag_v_q[s]);
    end
  end

  assign can_issue = !reset && (outstanding < 32'(FIFO_DEPTH));
  assign busy      = (outstanding != 32'd0);

  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = req_valid;
  end

  assign gnt_full  = rr_next_grant(valid_ext, t_req_id'(ptr_q), NUM_REQ);
  assign req_ready = can_issue ? gnt_full[NUM_REQ-1:0] : '0;
  assign transfer  = can_issue && (|gnt_full);

  always_comb begin
    gnt_idx = '0;
    mul_a_d = '0;
    mul_b_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        gnt_idx = ID_W'(i);
        mul_a_d = req_a[i*DATA_LEN +: DATA_LEN];
        mul_b_d = req_b[i*DATA_LEN +: DATA_LEN];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q         <= ID_W'(NUM_REQ - 1);
      tag_v_q       <= '0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      issue_count_q <= '0;
    end else begin
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      tag_v_q <= {tag_v_q[MUL_LATENCY-1:0], transfer};
      if (transfer) begin
        ptr_q         <= gnt_idx;
        issue_count_q <= issue_count_q + 32'd1;
      end
    end
  end

  // IDs need no reset: they are only consumed alongside a valid tag.
  always_ff @(posedge clk) begin
    tag_id_q[0] <= gnt_idx;
    for (int s = 1; s <= MUL_LATENCY; s++) begin
      tag_id_q[s] <= tag_id_q[s-1];
    end
  end

  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign issue_count = issue_count_q;

  assign cap_valid = tag_v_q[MUL_LATENCY];
  assign fifo_pop  = rsp_valid && rsp_ready;
  assign fifo_push = cap_valid && (!fifo_full || fifo_pop);

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_rsp_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .wdata_i ({tag_id_q[MUL_LATENCY], mul_result}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign rsp_valid  = !fifo_empty;
  assign rsp_id     = fifo_rdata[ENT_W-1 -: ID_W];
  assign rsp_result = fifo_rdata[DATA_LEN-1:0];

endmodule

// File: tb/tb_mul_rr_scheduler.sv
// Directed bench for mul_rr_scheduler: default instance plus a FIFO_DEPTH=4 instance.
// Valid/ready: a request transfers in any cycle where req_valid[i] & req_ready[i]; a response pops where rsp_valid & rsp_ready.
module tb_mul_rr_scheduler;

  localparam int W = 34;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid, req_ready;
  logic [127:0] req_a, req_b;
  logic [31:0]  mul_a, mul_b, mul_result;
  logic         rsp_valid, rsp_ready, busy;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_result, issue_count;

  logic [3:0]   req_valid4, req_ready4;
  logic [127:0] req_a4, req_b4;
  logic [31:0]  mul_a4, mul_b4, mul_result4;
  logic         rsp_valid4, rsp_ready4, busy4;
  logic [1:0]   rsp_id4;
  logic [31:0]  rsp_result4, issue_count4;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_q4[$];
  int           errors = 0;
  int           checks = 0;
  bit           mon4_en = 1'b0;
  int           grants4 = 0;

  logic [31:0] mpipe  [3];
  logic [31:0] mpipe4 [3];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: sim time exceeded, required completion");
    $fatal(1, "timeout");
  end

  mul_rr_scheduler dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b), .mul_result(mul_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .busy(busy), .issue_count(issue_count)
  );

  mul_rr_scheduler #(.FIFO_DEPTH(4)) dut4 (
    .clk(clk), .reset(reset), .req_valid(req_valid4), .req_ready(req_ready4),
    .req_a(req_a4), .req_b(req_b4), .mul_a(mul_a4), .mul_b(mul_b4), .mul_result(mul_result4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_id(rsp_id4), .rsp_result(rsp_result4),
    .busy(busy4), .issue_count(issue_count4)
  );

  // 3-stage multiplier models
  always @(posedge clk) begin
    mpipe[0]  <= mul_a * mul_b;
    mpipe[1]  <= mpipe[0];
    mpipe[2]  <= mpipe[1];
    mpipe4[0] <= mul_a4 * mul_b4;
    mpipe4[1] <= mpipe4[0];
    mpipe4[2] <= mpipe4[1];
  end
  assign mul_result  = mpipe[2];
  assign mul_result4 = mpipe4[2];

  // ---------------- scoreboards ----------------
  always begin
    logic [W-1:0] e;
    @(negedge clk);
    #2;
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_extra: got id=%0d result=%h, required no response", rsp_id, rsp_result);
      end else begin
        e = exp_q.pop_front();
        if ({rsp_id, rsp_result} !== e) begin
          errors++;
          $display("FAIL rsp_order: got id=%0d result=%h, required id=%0d result=%h",
                   rsp_id, rsp_result, e[33:32], e[31:0]);
        end
      end
    end
    if (dut.cap_valid === 1'b1) begin
      checks++;
      if (dut.fifo_full && !dut.fifo_pop) begin
        errors++;
        $display("FAIL fifo_overflow: push into full fifo, required no push when full");
      end
    end
  end

  always begin
    logic [W-1:0] e;
    @(negedge clk);
    #2;
    if (mon4_en) begin
      for (int i = 0; i < 4; i++) begin
        if (req_valid4[i] && req_ready4[i]) begin
          exp_q4.push_back({2'(i), req_a4[i*32 +: 32] * req_b4[i*32 +: 32]});
          grants4++;
        end
      end
      checks++;
      if (dut4.u_rsp_fifo.count_q > 3'd4) begin
        errors++;
        $display("FAIL fifo4_count: count=%0d, required <= 4", dut4.u_rsp_fifo.count_q);
      end
    end
    if (rsp_valid4 === 1'b1 && rsp_ready4 === 1'b1) begin
      checks++;
      if (exp_q4.size() == 0) begin
        errors++;
        $display("FAIL rsp4_extra: got id=%0d result=%h, required no response", rsp_id4, rsp_result4);
      end else begin
        e = exp_q4.pop_front();
        if ({rsp_id4, rsp_result4} !== e) begin
          errors++;
          $display("FAIL rsp4_order: got id=%0d result=%h, required id=%0d result=%h",
                   rsp_id4, rsp_result4, e[33:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    req_valid  = '0;
    req_valid4 = '0;
    rsp_ready  = 1'b0;
    rsp_ready4 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    req_valid4 = '0; req_a4 = '0; req_b4 = '0; rsp_ready4 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (mul_a !== 32'd0 || mul_b !== 32'd0) begin errors++;
      $display("FAIL reset_mul: mul_a=%h mul_b=%h, required 0", mul_a, mul_b); end
    checks++; if (req_ready !== 4'b0000) begin errors++;
      $display("FAIL reset_ready: req_ready=%b, required 0000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++;
      $display("FAIL reset_rsp_valid: %b, required 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy: %b, required 0", busy); end
    checks++; if (issue_count !== 32'd0) begin errors++;
      $display("FAIL reset_issue_count: %0d, required 0", issue_count); end
  endtask

  task automatic test_single();
    @(negedge clk);
    rsp_ready = 1'b1; req_valid = 4'b0001; req_a[31:0] = 32'd6; req_b[31:0] = 32'd7;
    exp_q.push_back({2'd0, 32'd42});
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++;
      $display("FAIL single_grant: req_ready=%b, required 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (mul_a !== 32'd6 || mul_b !== 32'd7) begin errors++;
      $display("FAIL single_operands: mul_a=%0d mul_b=%0d, required 6 7", mul_a, mul_b); end
    checks++; if (busy !== 1'b1) begin errors++;
      $display("FAIL single_busy: %b, required 1", busy); end
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++;
        $display("FAIL single_early_rsp: cycle %0d rsp_valid=%b, required 0", c, rsp_valid); end
    end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 32'd42) begin errors++;
      $display("FAIL single_rsp: valid=%b id=%0d result=%0d, required 1 0 42", rsp_valid, rsp_id, rsp_result); end
    @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++;
      $display("FAIL single_idle: busy=%b rsp_valid=%b, required 0 0", busy, rsp_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = 32'(i + 1);
      req_b[i*32 +: 32] = 32'd10;
    end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req_valid = 4'hF;
      exp_q.push_back({2'(k % 4), 32'((k % 4 + 1) * 10)});
      #1;
      checks++; if (req_ready !== 4'(1 << (k % 4))) begin errors++;
        $display("FAIL rr_grant: cycle %0d req_ready=%b, required %b", k, req_ready, 4'(1 << (k % 4))); end
    end
    @(negedge clk);
    req_valid = '0;
    for (int n = 0; n < 60 && (exp_q.size() != 0 || busy !== 1'b0); n++) @(negedge clk);
    checks++; if (exp_q.size() != 0 || busy !== 1'b0) begin errors++;
      $display("FAIL rr_drain: pending=%0d busy=%b, required 0 0", exp_q.size(), busy); end
    checks++; if (issue_count !== 32'd5) begin errors++;
      $display("FAIL rr_issue_count: %0d, required 5", issue_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = 32'(100 + i);
      req_b[i*32 +: 32] = 32'd3;
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req_valid = 4'hF;
      exp_q.push_back({2'(k % 4), 32'(3 * (100 + k % 4))});
      #1;
      checks++; if (req_ready !== 4'(1 << (k % 4))) begin errors++;
        $display("FAIL bp_grant: cycle %0d req_ready=%b, required %b", k, req_ready, 4'(1 << (k % 4))); end
    end
    for (int k = 8; k < 10; k++) begin
      @(negedge clk);
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++;
        $display("FAIL bp_stall: cycle %0d req_ready=%b, required 0000", k, req_ready); end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b1) begin errors++;
      $display("FAIL bp_pop_cycle: req_ready=%b rsp_valid=%b, required 0000 1", req_ready, rsp_valid); end
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_q.push_back({2'd0, 32'd300});
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++;
      $display("FAIL bp_regrant: req_ready=%b, required 0001", req_ready); end
    @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++;
      $display("FAIL bp_restall: req_ready=%b, required 0000", req_ready); end
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int n = 0; n < 60 && (exp_q.size() != 0 || busy !== 1'b0); n++) @(negedge clk);
    checks++; if (exp_q.size() != 0 || busy !== 1'b0) begin errors++;
      $display("FAIL bp_drain: pending=%0d busy=%b, required 0 0", exp_q.size(), busy); end
    checks++; if (issue_count !== 32'd9) begin errors++;
      $display("FAIL bp_issue_count: %0d, required 9", issue_count); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = 32'(i + 1);
      req_b[i*32 +: 32] = 32'd5;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req_valid = 4'b0111;
      #1;
      checks++; if (req_ready !== 4'(1 << k)) begin errors++;
        $display("FAIL mid_grant: cycle %0d req_ready=%b, required %b", k, req_ready, 4'(1 << k)); end
    end
    @(negedge clk);
    req_valid = '0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL mid_after_reset: rsp_valid=%b busy=%b, required 0 0", rsp_valid, busy); end
    checks++; if (issue_count !== 32'd0 || mul_a !== 32'd0) begin errors++;
      $display("FAIL mid_counters: issue_count=%0d mul_a=%0d, required 0 0", issue_count, mul_a); end
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++;
        $display("FAIL mid_stale: cycle %0d rsp_valid=%b busy=%b, required 0 0", c, rsp_valid, busy); end
    end
    @(negedge clk);
    req_valid = 4'hF;
    exp_q.push_back({2'd0, 32'd5});
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++;
      $display("FAIL mid_first_grant: req_ready=%b, required 0001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    for (int n = 0; n < 60 && (exp_q.size() != 0 || busy !== 1'b0); n++) @(negedge clk);
    checks++; if (exp_q.size() != 0 || busy !== 1'b0) begin errors++;
      $display("FAIL mid_drain: pending=%0d busy=%b, required 0 0", exp_q.size(), busy); end
  endtask

  task automatic test_wrap_edge();
    do_reset();
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 4'b0100;
    req_a[64 +: 32] = 32'hFFFF_FFFF;
    req_b[64 +: 32] = 32'd2;
    exp_q.push_back({2'd2, 32'hFFFF_FFFE});
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++;
      $display("FAIL edge_grant: req_ready=%b, required 0100", req_ready); end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      req_valid = 4'(1 << (k % 4));
      req_a[(k % 4)*32 +: 32] = 32'(k + 1);
      req_b[(k % 4)*32 +: 32] = 32'(k + 3);
      exp_q.push_back({2'(k % 4), 32'((k + 1) * (k + 3))});
      #1;
      checks++; if (req_ready !== 4'(1 << (k % 4))) begin errors++;
        $display("FAIL wrap_grant: txn %0d req_ready=%b, required %b", k, req_ready, 4'(1 << (k % 4))); end
    end
    @(negedge clk);
    req_valid = '0;
    for (int n = 0; n < 60 && (exp_q.size() != 0 || busy !== 1'b0); n++) @(negedge clk);
    checks++; if (exp_q.size() != 0 || busy !== 1'b0) begin errors++;
      $display("FAIL wrap_drain: pending=%0d busy=%b, required 0 0", exp_q.size(), busy); end
    checks++; if (issue_count !== 32'd21) begin errors++;
      $display("FAIL wrap_issue_count: %0d, required 21", issue_count); end
  endtask

  // Depth 4 with 3-cycle latency: each request holds a credit for 5 cycles, so
  // the grant pattern settles to 4 grants then 2 stalls.
  task automatic test_throughput4();
    logic [3:0] exp_gnt;
    int         g;
    do_reset();
    g = 0;
    rsp_ready4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_a4[i*32 +: 32] = 32'(i + 1);
      req_b4[i*32 +: 32] = 32'd7;
    end
    mon4_en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      req_valid4 = 4'hF;
      #1;
      if (k % 6 < 4) begin
        exp_gnt = 4'(1 << (g % 4));
        g++;
      end else begin
        exp_gnt = 4'b0000;
      end
      checks++; if (req_ready4 !== exp_gnt) begin errors++;
        $display("FAIL tp4_grant: cycle %0d req_ready=%b, required %b", k, req_ready4, exp_gnt); end
    end
    @(negedge clk);
    req_valid4 = '0;
    for (int n = 0; n < 60 && (exp_q4.size() != 0 || busy4 !== 1'b0); n++) @(negedge clk);
    mon4_en = 1'b0;
    checks++; if (exp_q4.size() != 0 || busy4 !== 1'b0) begin errors++;
      $display("FAIL tp4_drain: pending=%0d busy=%b, required 0 0", exp_q4.size(), busy4); end
    checks++; if (grants4 != 20 || issue_count4 !== 32'd20) begin errors++;
      $display("FAIL tp4_total: grants=%0d issue_count=%0d, required 20 20", grants4, issue_count4); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_midflight();
    test_wrap_edge();
    test_throughput4();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
